adder_rr_arbiter: RTL
=====================

// Module: adder_rr_arbiter
// PURPOSE
//   Shares one fourbit_adder instance (S[4:0] = A[3:0] + B[3:0]) among N_REQ requesters.
//   Round-robin arbitration with a valid/ready request handshake per requester.
//   Single-entry registered response port tagged with the requester ID.
//   Sits between client blocks and the adder datapath; sustains one add per cycle.
// PARAMETERS
//   N_REQ   4   number of requesters, 2..8
//   ID_W    2   requester ID width, clog2(N_REQ)
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        synchronous, active-high reset
//   req_valid  in   N_REQ    per-requester request valid
//   req_a      in   4*N_REQ  operand A, requester i at [4i+3:4i]
//   req_b      in   4*N_REQ  operand B, requester i at [4i+3:4i]
//   req_ready  out  N_REQ    one-hot grant; accept = valid & ready
//   rsp_valid  out  1        response valid
//   rsp_ready  in   1        downstream accepts response
//   rsp_id     out  ID_W     index of the served requester
//   rsp_sum    out  5        A+B with carry in bit 4
// BEHAVIOUR
//   Reset: rsp_valid=0, rsp_id=0, operand regs=0 (rsp_sum=0), rr pointer=N_REQ-1
//     (requester 0 has first priority), req_ready=0.
//   FSM: EMPTY (slot free), FULL (rsp_valid=1).
//     EMPTY -> FULL on any accept. FULL -> EMPTY on rsp_ready with no accept.
//     FULL -> FULL on rsp_ready with a new accept, or on !rsp_ready.
//   Grant is enabled when the FSM is EMPTY, or FULL && rsp_ready (drain and refill in the same cycle).
//     Disabled grant forces req_ready=0.
//   req_ready is combinational from req_valid and the rr pointer. Winner = first valid requester
//     searching ptr+1, ptr+2, ... modulo N_REQ. At most one bit is set.
//   On accept: latch A, B and the ID into the response regs. ptr <= winner.
//     The pointer is unchanged when there is no accept.
//   rsp_sum = fourbit_adder(latched A, latched B), combinational from regs.
//   Latency: accept at edge k -> rsp_valid/rsp_sum valid after edge k. Throughput 1/cycle.
//   Response regs hold their value while rsp_valid && !rsp_ready (no overwrite).
//   Requester rules: valid must not depend on ready. Operands are held stable until accept.
//   Requesters never drop valid before accept.
//   Width: 4+4 -> 5 bits, never truncated. 15+15 = 30 = 5'b11110.
//   Single requester valid: granted every cycle the slot is available. No idle bubble.
//   Pointer wrap: after ID N_REQ-1 is served, the search starts at 0.
//   Reset mid-operation: an in-flight response is discarded (rsp_valid=0 next cycle).
//     No grant occurs in the reset cycle.
// CONFIGURATION
//   ADDER_ARB_STATS_EN defined: adds output ports
//     stat_grants [16*N_REQ-1:0]: per-requester accept counters, saturating at 16'hFFFF.
//     stat_stall [15:0]: counts cycles with |req_valid && no accept, saturating.
//     Both are cleared by rst.
//   Undefined: these ports and counters do not exist. The rest of the behaviour is identical.
// STRUCTURE
//   Package adder_arb_pkg:
//     OPND_W=4, SUM_W=5, STAT_W=16.
//     State enum {ARB_EMPTY, ARB_FULL}.
//   Sub-module rr_pick: req[N_REQ], ptr[ID_W] -> gnt one-hot, gnt_id, any.
//     Purely combinational.
//   Top: FSM, response regs, fourbit_adder instance, optional stats.
// TESTING
//   1. Reset, then req_valid=4'b0001, A=3, B=4, rsp_ready=1.
//      -> req_ready=0001; next cycle rsp_valid=1, id=0, sum=7.
//   2. All four valid, rsp_ready=1 for 8 cycles.
//      -> grants 0,1,2,3,0,1,2,3 back-to-back; one response per cycle with matching IDs.
//   3. A=15, B=15 on requester 2. -> rsp_sum=5'b11110 (30), id=2.
//   4. Response pending, rsp_ready=0 for 3 cycles, requesters 1 and 3 valid.
//      -> req_ready=0; response held.
//      Then rsp_ready=1 -> requester 1 granted the same cycle; response updates next cycle.
//   5. rst asserted while rsp_valid=1 and requests pending.
//      -> rsp_valid=0, req_ready=0; after release, requester 0 has priority.
//   6. ADDER_ARB_STATS_EN: requester 1 alone for 5 accepts, then 2 stalled cycles.
//      -> stat_grants[31:16]=5, stat_stall=2.

Source files
------------

// File: rtl/adder_rr_arbiter_pkg.sv
// adder_arb_pkg: shared widths, FSM state type and saturating-count helper for adder_rr_arbiter
package adder_arb_pkg;
    localparam int OPND_W = 4;
    localparam int SUM_W  = 5;
    localparam int STAT_W = 16;
    typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_t;
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/adder_rr_arbiter_if.sv
// adder_rr_arbiter_if: request/response bus between clients (master) and the shared adder arbiter (slave)
interface adder_rr_arbiter_if import adder_arb_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]        req_valid;
    logic [OPND_W*N_REQ-1:0] req_a;
    logic [OPND_W*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]        req_ready;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [SUM_W-1:0]        rsp_sum;
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );
endinterface

// File: rtl/adder_rr_arbiter_rr_pick.sv
// rr_pick / fourbit_adder: combinational round-robin winner search and the shared 4+4->5 bit adder
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);
    // Scan farthest offset first so the nearest requester after ptr overwrites and wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = |req;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                gnt    = '0;
                gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
                gnt_id = ID_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end
endmodule

module fourbit_adder import adder_arb_pkg::*; (
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [SUM_W-1:0]  s
);
    assign s = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin sharing of one fourbit_adder with a single-entry tagged response slot.
// Optional ADDER_ARB_STATS_EN adds saturating per-requester grant and stall counters.
module adder_rr_arbiter import adder_arb_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef ADDER_ARB_STATS_EN
    output logic [STAT_W*N_REQ-1:0] stat_grants,
    output logic [STAT_W-1:0]       stat_stall,
`endif
    adder_rr_arbiter_if.slave       bus
);
    arb_state_t        state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   id_q;
    logic [N_REQ-1:0]  gnt;
    logic              any;
    logic              grant_en;
    logic              accept;
    logic [OPND_W-1:0] a_q;
    logic [OPND_W-1:0] b_q;
    logic [SUM_W-1:0]  sum;
    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req    (bus.req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );
    fourbit_adder u_add (.a(a_q), .b(b_q), .s(sum));
    // The slot can refill in the same cycle it drains; reset blocks any grant.
    assign grant_en      = !rst && (state == ARB_EMPTY || bus.rsp_ready);
    assign accept        = grant_en && any;
    assign bus.req_ready = grant_en ? gnt : '0;
    assign bus.rsp_valid = state == ARB_FULL;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_EMPTY;
            ptr   <= ID_W'(N_REQ - 1);
            id_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (accept) begin
            state <= ARB_FULL;
            ptr   <= gnt_id;
            id_q  <= gnt_id;
            a_q   <= bus.req_a[OPND_W*int'(gnt_id) +: OPND_W];
            b_q   <= bus.req_b[OPND_W*int'(gnt_id) +: OPND_W];
        end else if (bus.rsp_ready) begin
            state <= ARB_EMPTY;
        end
    end
`ifdef ADDER_ARB_STATS_EN
    logic [STAT_W-1:0] grants [N_REQ];
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++)
            grants[i] <= rst ? '0 : (bus.req_valid[i] && bus.req_ready[i]) ? sat_inc(grants[i]) : grants[i];
        stat_stall <= rst ? '0 : (|bus.req_valid && !accept) ? sat_inc(stat_stall) : stat_stall;
    end
    for (genvar i = 0; i < N_REQ; i++) begin : g_stat
        assign stat_grants[STAT_W*i +: STAT_W] = grants[i];
    end
`endif
endmodule
